nibble_serial_addsub_ctrl: RTL and testbench



---
 rtl/nibble_serial_addsub_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_addsub_ctrl_fourbi_adder.sv | 22 ++
 rtl/nibble_serial_addsub_ctrl.sv | 121 ++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibble_serial_addsub_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_fourbi_adder.sv
// 4-bit ripple-carry adder: the single nibble datapath shared by every pass.
module fourbi_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    // Full-adder chain, carry rippling from bit 0 upwards.
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock (LSB first) through a
// single 4-bit adder, with valid/ready handshakes on operands and result.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | one adder pass per clock, nibble idx written into result
// DONE  | result/carry_out/overflow held, out_valid=1 until out_ready
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      idx;
    logic                  carry_r;
    logic [WIDTH-1:0]      a_r;
    logic [WIDTH-1:0]      b_r;
    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   sum_nib;
    logic                  cout_nib;
    logic                  last;

    assign a_nib = a_r[idx * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_r[idx * NIBBLE_W +: NIBBLE_W];
    assign last  = (idx == LAST_IDX);

    fourbi_adder u_adder (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_r),
        .sum  (sum_nib),
        .cout (cout_nib)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, per-nibble write-back and final flag capture.
    // Subtraction is pre-inverted into b_r with carry-in 1 so RUN is a plain add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    result[idx * NIBBLE_W +: NIBBLE_W] <= sum_nib;
                    carry_r <= cout_nib;
                    if (last) begin
                        carry_out <= cout_nib;
                        overflow  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (sum_nib[NIBBLE_W-1] != a_r[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Bench for nibble_serial_addsub_ctrl (WIDTH=16): directed vector table,
// handshake and reset corner sequences, then random operations against an
// arithmetic reference model.
module tb_nibble_serial_addsub_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] exp_result;
        logic        exp_carry;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands as unsigned and signed values.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                         output logic [15:0] r, output logic c, output logic ov);
        int ua, ub, sa, sb, sres;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            r    = 16'(ua - ub);
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            r    = 16'(ua + ub);
            c    = (ua + ub) > 65535;
            sres = sa + sb;
        end
        ov = (sres > 32767) || (sres < -32768);
    endtask

    // Accept one operation, scramble the inputs while it runs, wait for out_valid.
    task automatic start_op(input logic [15:0] oa, input logic [15:0] ob, input logic osub,
                            output int lat);
        @(negedge clk);
        a = oa; b = ob; sub = osub; in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          lat;
        logic [15:0] er;
        logic        ec, eo;
        logic [15:0] held;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0009, 16'h0003, 1'b1, 16'h0006, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        // Reset state.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // out_ready while idle does nothing.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_ready_no_effect", 32'(out_valid), 32'd0);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            check("vec_latency", 32'(lat), 32'(NIBBLES));
            check("vec_result", 32'(result), 32'(vecs[i].exp_result));
            check("vec_carry", 32'(carry_out), 32'(vecs[i].exp_carry));
            check("vec_overflow", 32'(overflow), 32'(vecs[i].exp_ov));
            consume();
        end

        // Back-pressure in DONE: outputs held, no accept.
        start_op(16'h1234, 16'h0FFF, 1'b0, lat);
        held = result;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); in_valid = ~in_valid; sub = 1'($urandom);
            @(posedge clk);
            #1;
            check("hold_result", 32'(result), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        check("hold_value", 32'(held), 32'h2233);
        consume();

        // Reset in the middle of RUN.
        start_op(16'h1111, 16'h2222, 1'b0, lat);
        consume();
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_carry", 32'(carry_out), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'h0001, 16'h0001, 1'b0, lat);
        check("postrst_latency", 32'(lat), 32'(NIBBLES));
        check("postrst_result", 32'(result), 32'h0002);
        consume();

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            model(ra, rb, rs, er, ec, eo);
            start_op(ra, rb, rs, lat);
            check("rnd_latency", 32'(lat), 32'(NIBBLES));
            check("rnd_result", 32'(result), 32'(er));
            check("rnd_carry", 32'(carry_out), 32'(ec));
            check("rnd_overflow", 32'(overflow), 32'(eo));
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
